// File: rtl/imem_loader_pkg.sv
// Shared processor definitions plus the boot loader's state encoding and frame constants.
package imem_loader_pkg;
    localparam int I_WIDTH = 9;
    localparam int P_WIDTH = 12;

    typedef enum logic [2:0] {
        OP_ALU    = 3'b000,
        OP_ALUI   = 3'b001,
        OP_LOAD   = 3'b010,
        OP_STORE  = 3'b011,
        OP_BRANCH = 3'b100,
        OP_SHIFT  = 3'b101,
        OP_JUMP   = 3'b110,
        OP_SYS    = 3'b111
    } op_mne;

    localparam logic [1:0] FUNCT_SLL = 2'b01;
    localparam logic [1:0] FUNCT_SRL = 2'b10;

    localparam logic [7:0] LEN_HI_MASK = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_INS_LO,
        ST_INS_HI,
        ST_CSUM,
        ST_DONE
    } ld_state_e;

    function automatic logic takes_byte(ld_state_e s);
        return s inside {ST_HDR_LO, ST_HDR_HI, ST_INS_LO, ST_INS_HI, ST_CSUM};
    endfunction
endpackage

// File: rtl/imem_loader_if.sv
// Byte stream with valid/ready handshake feeding the loader.
interface imem_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/imem_loader_instr_checker.sv
// Combinational decode of a shift opcode whose funct is neither SLL nor SRL.
module instr_checker
    import imem_loader_pkg::*;
(
    input  logic [I_WIDTH-1:0] instr,
    output logic               illegal_shift
);
    op_mne      opcode;
    logic [1:0] funct;

    assign opcode        = op_mne'(instr[I_WIDTH-1 -: 3]);
    assign funct         = instr[1:0];
    assign illegal_shift = (opcode == OP_SHIFT) && (funct != FUNCT_SLL) && (funct != FUNCT_SRL);
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte frame and writes 9-bit words into instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [P_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    imem_loader_if.slave       s,
    output logic               imem_we,
    output logic [P_WIDTH-1:0] imem_waddr,
    output logic [I_WIDTH-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err_hdr,
    output logic               err_fmt,
    output logic               err_csum,
    output logic [7:0]         warn_cnt
);
    ld_state_e          state_q, state_d;
    logic [P_WIDTH-1:0] len_q, len_d;
    logic [P_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         xor_q, xor_d;
    logic               we_q, we_d;
    logic [P_WIDTH-1:0] waddr_q, waddr_d;
    logic [I_WIDTH-1:0] wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               err_hdr_q, err_hdr_d;
    logic               err_fmt_q, err_fmt_d;
    logic               err_csum_q, err_csum_d;
    logic [7:0]         warn_q, warn_d;

    logic               rdy, accept, illegal;
    logic [I_WIDTH-1:0] instr;
    logic [P_WIDTH-1:0] hdr_len;

    assign rdy     = takes_byte(state_q);
    assign accept  = rdy && s.s_valid;
    assign instr   = {s.s_data[0], lo_q};
    assign hdr_len = {s.s_data[3:0], lo_q};

    instr_checker u_chk (.instr(instr), .illegal_shift(illegal));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        lo_d       = lo_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_hdr_d  = err_hdr_q;
        err_fmt_d  = err_fmt_q;
        err_csum_d = err_csum_q;
        warn_d     = warn_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_HDR_LO;
                    idx_d      = '0;
                    xor_d      = '0;
                    err_hdr_d  = 1'b0;
                    err_fmt_d  = 1'b0;
                    err_csum_d = 1'b0;
                    warn_d     = '0;
                end
            end
            ST_HDR_LO, ST_INS_LO: begin
                if (accept) begin
                    lo_d    = s.s_data;
                    xor_d   = xor_q ^ s.s_data;
                    state_d = (state_q == ST_HDR_LO) ? ST_HDR_HI : ST_INS_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    xor_d = xor_q ^ s.s_data;
                    len_d = hdr_len;
                    if ((s.s_data & LEN_HI_MASK) != 8'h00) begin
                        err_hdr_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (hdr_len == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_INS_LO;
                    end
                end
            end
            ST_INS_HI: begin
                if (accept) begin
                    xor_d   = xor_q ^ s.s_data;
                    we_d    = 1'b1;
                    waddr_d = BASE_ADDR + idx_q;
                    wdata_d = instr;
                    idx_d   = idx_q + 1'b1;
                    if (s.s_data[7:1] != 7'd0)
                        err_fmt_d = 1'b1;
                    if (illegal && warn_q != 8'hFF)
                        warn_d = warn_q + 8'd1;
                    state_d = (idx_q + 1'b1 == len_q) ? ST_CSUM : ST_INS_LO;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (s.s_data != xor_q)
                        err_csum_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pulse only on entry; restarting out of DONE never re-fires it.
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            lo_q       <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_hdr_q  <= 1'b0;
            err_fmt_q  <= 1'b0;
            err_csum_q <= 1'b0;
            warn_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_hdr_q  <= err_hdr_d;
            err_fmt_q  <= err_fmt_d;
            err_csum_q <= err_csum_d;
            warn_q     <= warn_d;
        end
    end

    assign s.s_ready  = rdy;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = done_q;
    assign err_hdr    = err_hdr_q;
    assign err_fmt    = err_fmt_q;
    assign err_csum   = err_csum_q;
    assign warn_cnt   = warn_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that writes 9-bit instructions into instruction memory. Instruction memory is the structure the core's fetch stage reads from.
- Takes a byte stream with a valid/ready handshake (from UART/JTAG glue) and writes instructions on a single-port write interface.
- Holds the core in stall (busy) while loading.
- Parses the frame, checks its format and an XOR checksum, and flags illegal shift encodings.

Parameters:
- I_WIDTH, 9, instruction width (from shared package)
- P_WIDTH, 12, instruction memory address width (from shared package)
- BASE_ADDR, 0, first instruction memory address written; P_WIDTH bits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE/DONE
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  instruction memory write enable
- imem_waddr  out  P_WIDTH  write address
- imem_wdata  out  I_WIDTH  write data
- busy  out  1  load in progress; core must stall
- done  out  1  one-cycle pulse at end of frame
- err_hdr  out  1  sticky: header invalid
- err_fmt  out  1  sticky: nonzero pad bits in an instruction
- err_csum  out  1  sticky: checksum mismatch
- warn_cnt  out  8  saturating count of shift instructions with illegal funct

Behaviour:
- Frame layout:
  - LEN_LO, LEN_HI: N = {LEN_HI[3:0], LEN_LO}.
  - N instruction pairs (LO, HI): instr = {HI[0], LO}.
  - CSUM byte.
- Byte transfer occurs when s_valid && s_ready.
- s_ready is 1 only in HDR_LO, HDR_HI, INS_LO, INS_HI and CSUM. One byte per cycle maximum, no bubbles required.
- States and transitions:
  - IDLE: on start -> HDR_LO; clear sticky errors, warn_cnt and the running XOR.
  - HDR_LO: on byte -> HDR_HI.
  - HDR_HI:
    - on byte with upper nibble != 0 -> set err_hdr, go to DONE. No writes.
    - else if N == 0 -> CSUM.
    - else -> INS_LO.
  - INS_LO: on byte -> INS_HI.
  - INS_HI: on byte -> issue a write. If this was the N-th instruction -> CSUM, else -> INS_LO.
  - CSUM: on byte -> compare with running XOR, set err_csum if unequal, go to DONE.
  - DONE: done = 1 for exactly the entry cycle. Remains in DONE; start -> HDR_LO with the same clears as from IDLE.
- Write timing:
  - imem_we is registered and pulses for one cycle, the cycle after the INS_HI byte is accepted.
  - imem_waddr = (BASE_ADDR + index) mod 2^P_WIDTH, where index counts 0..N-1. Wrap past 4095 to 0 is legal and silent.
- Pad bits: HI[7:1] != 0 sets err_fmt, but the word is still written.
- Illegal shift encoding: opcode = instr[8:6], funct = instr[1:0]. If opcode == OP_SHIFT and funct is not FUNCT_SLL or FUNCT_SRL, increment warn_cnt (saturate at 255). The word is still written.
- Checksum: running XOR of every accepted byte from LEN_LO through the last INS_HI. The CSUM byte itself is excluded.
- busy = 1 in every state except IDLE and DONE.
  - busy stays 1 through the cycle in which the final imem_we is asserted.
  - done fires no earlier than the cycle after the final write.
- start is ignored while busy. If start and s_valid arrive in the same cycle in IDLE, the load starts; the byte is not accepted (s_ready = 0).
- Reset values, including reset mid-load:
  - state IDLE, imem_we 0, imem_waddr 0, imem_wdata 0.
  - busy 0, done 0, all errors 0, warn_cnt 0.
  - A pending write is dropped.

Decomposition:
- Shared package (existing processor definitions):
  - reuse I_WIDTH, P_WIDTH, the op_mne opcode enum (OP_SHIFT = 3'b101), FUNCT_SLL and FUNCT_SRL.
  - add the loader state enum and the frame constant LEN_HI_MASK = 8'hF0.
- One natural sub-module: instr_checker. Combinational: instr -> illegal-shift flag. It is reused later by the core's decoder for illegal-instruction traps.

Test Plan:
- Normal load, BASE_ADDR=0: start, then bytes 02,00, 41,01 (instr 9'h141, OP_SHIFT, funct 01), 05,00 (instr 9'h005), CSUM 47 -> writes addr0=9'h141 and addr1=9'h005, done one cycle later, no errors, warn_cnt 0.
- Bad checksum: same frame with CSUM 00 -> both words written, err_csum = 1, done pulses.
- Header and pad errors:
  - LEN_HI = 8'h10 -> err_hdr = 1, zero imem_we pulses, DONE.
  - Instruction HI byte = 8'h03 -> err_fmt = 1, word written with bit8 = 1.
- Illegal shift and N=0:
  - instr 9'h140 (funct 00) -> warn_cnt = 1, word still written.
  - Frame 00,00,00 -> no writes, done pulses, no errors.
- Backpressure, wrap and reset:
  - s_valid toggling every other cycle -> writes identical to the back-to-back case.
  - BASE_ADDR = 12'hFFF with N = 2 -> addresses FFF then 000.
  - reset asserted after the first LO byte -> IDLE, no write, all outputs 0.
